// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the stream_mux_rr multiplexer.
package stream_mux_rr_pkg;

    // Mode encodings for the MODE parameter
    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Ceiling log2, used to check that index widths match the channel count
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: pure combinational rotate/priority search, no storage.
// The channel after last_i gets first priority; the search wraps modulo NUM_CH.
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
)
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  last_i,
    input  logic              en_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [IDX_W-1:0]  idx_o
);

    // First requester found after last_i wins; nothing is granted when disabled
    always_comb begin
        int               c;
        logic             found;
        logic [IDX_W-1:0] cand;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        c       = 0;
        cand    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            // Wrap by NUM_CH, not by 2**IDX_W, so unused indices are never produced
            c = int'(last_i) + k;
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end
            cand = IDX_W'(c);
            if (en_i && !found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// NUM_CH-input stream multiplexer with a registered output stage and
// valid/ready handshakes. MODE selects explicit steering via sel or
// round-robin arbitration across requesting channels.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = 1
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch
);

    if (SEL_W != clog2(NUM_CH)) begin : g_bad_sel_w
        $error("stream_mux_rr: SEL_W must equal clog2(NUM_CH)");
    end
    if (MODE != MODE_SEL && MODE != MODE_RR) begin : g_bad_mode
        $error("stream_mux_rr: MODE must be 0 or 1");
    end

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]  rr_last_q,   rr_last_d;

    logic              load;
    logic              xfer;
    logic [NUM_CH-1:0] sel_grant;
    logic [NUM_CH-1:0] rr_grant;
    logic [SEL_W-1:0]  rr_idx;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  mux_data;

    // The output register can accept a beat when empty or draining this cycle
    assign load = !out_valid_q || out_ready;

    // Explicit-select grant: sel values beyond the last channel grant nothing
    always_comb begin
        sel_grant = '0;
        if (int'(sel) < NUM_CH) begin
            sel_grant[sel] = in_valid[sel];
        end
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (SEL_W)
    ) u_arb (
        .req_i   (in_valid),
        .last_i  (rr_last_q),
        .en_i    (load && (MODE == MODE_RR)),
        .grant_o (rr_grant),
        .idx_o   (rr_idx)
    );

    assign grant     = (MODE == MODE_RR) ? rr_grant : sel_grant;
    assign grant_idx = (MODE == MODE_RR) ? rr_idx   : sel;
    assign in_ready  = load ? grant : '0;
    assign xfer      = load && (|grant);

    // One-hot data select from the granted channel
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                mux_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state: load on transfer, empty on idle load, hold while stalled
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_last_d   = rr_last_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = mux_data;
                out_ch_d   = grant_idx;
                if (MODE == MODE_RR) begin
                    rr_last_d = grant_idx;
                end
            end
        end
    end

    // State registers; reset leaves channel 0 with first priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_last_q   <= SEL_W'(NUM_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: four instances (RR/SEL x 4/3 channels) share
// clock and reset; a behavioural model predicts in_ready and out_valid,
// and a scoreboard queue holds beats until the DUT presents them.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst;

    logic [3:0][3:0]  iv;
    logic [3:0][63:0] id;
    logic [3:0][1:0]  sl;
    logic [3:0]       ordy;

    wire  [3:0]       ov;
    wire  [3:0][15:0] od;
    wire  [3:0][1:0]  och;
    wire  [3:0][3:0]  ird;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  ch;
    } beat_t;

    beat_t sb[$];
    int    nch[4] = '{4, 4, 3, 3};
    int    md[4]  = '{1, 0, 1, 0};
    int    rr_last[4];
    bit    exp_ov[4];
    int    n_chk  = 0;
    int    n_fail = 0;
    logic [15:0] held_data;
    logic [1:0]  held_ch;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(16), .NUM_CH(4), .SEL_W(2), .MODE(1)) u_rr4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ird[0]), .in_data(id[0]),
        .sel(sl[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_ch(och[0]));
    stream_mux_rr #(.WIDTH(16), .NUM_CH(4), .SEL_W(2), .MODE(0)) u_sel4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ird[1]), .in_data(id[1]),
        .sel(sl[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_ch(och[1]));
    stream_mux_rr #(.WIDTH(16), .NUM_CH(3), .SEL_W(2), .MODE(1)) u_rr3 (
        .clk(clk), .rst(rst), .in_valid(iv[2][2:0]), .in_ready(ird[2][2:0]), .in_data(id[2][47:0]),
        .sel(sl[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_ch(och[2]));
    stream_mux_rr #(.WIDTH(16), .NUM_CH(3), .SEL_W(2), .MODE(0)) u_sel3 (
        .clk(clk), .rst(rst), .in_valid(iv[3][2:0]), .in_ready(ird[3][2:0]), .in_data(id[3][47:0]),
        .sel(sl[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .out_ch(och[3]));

    assign ird[2][3] = 1'b0;
    assign ird[3][3] = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            exp_ov[d]  = 1'b0;
            rr_last[d] = nch[d] - 1;
        end
        sb.delete();
    endtask

    // Called at a falling edge with inputs for DUT d already driven.
    task automatic step(input int d);
        int         g;
        int         c;
        bit         ld;
        logic [3:0] exp_rdy;
        beat_t      b;
        #1;
        ld = !exp_ov[d] || ordy[d];
        g  = -1;
        if (md[d] == 0) begin
            if (int'(sl[d]) < nch[d] && iv[d][sl[d]]) g = int'(sl[d]);
        end else begin
            for (int k = 1; k <= nch[d]; k++) begin
                c = (rr_last[d] + k) % nch[d];
                if (g < 0 && iv[d][c]) g = c;
            end
        end
        exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("in_ready", 32'(ird[d]), 32'(exp_rdy));
        chk("out_valid", 32'(ov[d]), 32'(exp_ov[d]));
        if (ov[d] && ordy[d]) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(ov[d]), 32'd0);
            end else begin
                b = sb.pop_front();
                chk("sb_data", 32'(od[d]), 32'(b.data));
                chk("sb_ch", 32'(och[d]), 32'(b.ch));
            end
        end
        if (ld) begin
            if (g >= 0) begin
                b.data = id[d][g*16 +: 16];
                b.ch   = 2'(g);
                sb.push_back(b);
                if (md[d] == 1) rr_last[d] = g;
            end
            exp_ov[d] = (g >= 0);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int d);
        iv[d]   = '0;
        ordy[d] = 1'b1;
        step(d);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst  = 1'b1;
        iv   = '0;
        id   = '0;
        sl   = '0;
        ordy = '1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state of every instance
        for (int d = 0; d < 4; d++) begin
            chk("rst_ov", 32'(ov[d]), 32'd0);
            chk("rst_data", 32'(od[d]), 32'd0);
            chk("rst_ch", 32'(och[d]), 32'd0);
            step(d);
        end

        // RR, 4 channels, all valid: A0..A3 repeating
        id[0] = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        iv[0] = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step(0);
            chk("rr4_valid", 32'(ov[0]), 32'd1);
            chk("rr4_data", 32'(od[0]), 32'(16'h00A0 + 16'(i % 4)));
            chk("rr4_ch", 32'(och[0]), 32'(i % 4));
        end

        // Only channels 1 and 3 request, then only channel 1
        iv[0] = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step(0);
            chk("alt_ch", 32'(och[0]), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        iv[0] = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step(0);
            chk("solo_valid", 32'(ov[0]), 32'd1);
            chk("solo_ch", 32'(och[0]), 32'd1);
        end

        // Backpressure: hold for 3 cycles, then drain and reload together
        iv[0] = 4'b1111;
        step(0);
        chk("bp_load_ch", 32'(och[0]), 32'd2);
        held_data = od[0];
        held_ch   = och[0];
        ordy[0]   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0);
            chk("stall_data", 32'(od[0]), 32'(held_data));
            chk("stall_ch", 32'(och[0]), 32'(held_ch));
            chk("stall_valid", 32'(ov[0]), 32'd1);
        end
        ordy[0] = 1'b1;
        step(0);
        chk("resume_ch", 32'(och[0]), 32'd3);
        chk("resume_data", 32'(od[0]), 32'h00A3);

        // Async reset while a beat is stalled
        ordy[0] = 1'b0;
        step(0);
        chk("pre_rst_valid", 32'(ov[0]), 32'd1);
        rst = 1'b1;
        #2;
        chk("async_rst_ov", 32'(ov[0]), 32'd0);
        chk("async_rst_data", 32'(od[0]), 32'd0);
        model_reset();
        @(negedge clk);
        rst     = 1'b0;
        iv[0]   = '0;
        ordy[0] = 1'b1;
        step(0);

        // Explicit select, 4 channels
        id[1] = {16'h0000, 16'h1234, 16'h0000, 16'h1111};
        sl[1] = 2'd2;
        iv[1] = 4'b0101;
        step(1);
        chk("sel2_data", 32'(od[1]), 32'h1234);
        chk("sel2_ch", 32'(och[1]), 32'd2);
        iv[1] = 4'b0001;
        step(1);
        chk("sel2_inval_ov", 32'(ov[1]), 32'd0);
        sl[1] = 2'd0;
        iv[1] = 4'b0101;
        step(1);
        chk("sel0_data", 32'(od[1]), 32'h1111);
        chk("sel0_ch", 32'(och[1]), 32'd0);
        drain(1);

        // RR, 3 channels: index wraps after 2
        id[2] = {16'h0000, 16'h00C2, 16'h00C1, 16'h00C0};
        iv[2] = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            step(2);
            chk("rr3_ch", 32'(och[2]), 32'(i % 3));
            chk("rr3_data", 32'(od[2]), 32'(16'h00C0 + 16'(i % 3)));
        end
        drain(2);

        // Explicit select, 3 channels: sel=3 grants nothing
        id[3] = {16'h0000, 16'h00D2, 16'h00D1, 16'h00D0};
        sl[3] = 2'd3;
        iv[3] = 4'b0111;
        #1;
        chk("sel3_none_rdy", 32'(ird[3]), 32'd0);
        @(negedge clk);
        step(3);
        chk("sel3_none_ov", 32'(ov[3]), 32'd0);
        sl[3] = 2'd1;
        step(3);
        chk("sel3_1_data", 32'(od[3]), 32'h00D1);
        chk("sel3_1_ch", 32'(och[3]), 32'd1);
        drain(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
